// File: rtl/banked_scratchpad.sv
// ---------------------------------------------------------------------------
// banked_scratchpad
//
// Dual-port scratchpad built from NUM_BANKS interleaved single-access banks.
// The low address bits select the bank and the high bits select the row. Two
// ports (A and B) can each start one access per cycle. When both ports hit the
// same bank in the same cycle, a toggling priority pointer decides which port
// is granted. The losing port waits and wins on the next cycle.
//
// Read latency is one cycle when OUT_REG=0 and two cycles when OUT_REG=1.
// Memory contents are not cleared by reset. While rst_n is low, no write is
// performed.
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   a_req / b_req             : access request, held until granted
//   a_we  / b_we              : 1 = write, 0 = read
//   a_addr / b_addr [AW]      : {row, bank}
//   a_wdata / b_wdata [D_WID] : write data
//   a_gnt / b_gnt             : combinational grant; access happens at the
//                               edge where req & gnt
//   a_rvalid / b_rvalid       : one-cycle read-data-valid pulse
//   a_rdata / b_rdata [D_WID] : read data, held between pulses
//   conflict_cnt [16]         : saturating count of bank-conflict cycles
// ---------------------------------------------------------------------------
module banked_scratchpad #(
    parameter int NUM_BANKS = 16,
    parameter int A_WID     = 10,
    parameter int D_WID     = 8,
    parameter int OUT_REG   = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 a_req,
    input  logic                                 a_we,
    input  logic [$clog2(NUM_BANKS)+A_WID-1:0]   a_addr,
    input  logic [D_WID-1:0]                     a_wdata,
    input  logic                                 b_req,
    input  logic                                 b_we,
    input  logic [$clog2(NUM_BANKS)+A_WID-1:0]   b_addr,
    input  logic [D_WID-1:0]                     b_wdata,
    output logic                                 a_gnt,
    output logic                                 b_gnt,
    output logic                                 a_rvalid,
    output logic                                 b_rvalid,
    output logic [D_WID-1:0]                     a_rdata,
    output logic [D_WID-1:0]                     b_rdata,
    output logic [15:0]                          conflict_cnt
);

    localparam int B_WID = $clog2(NUM_BANKS);
    localparam int AW    = B_WID + A_WID;
    localparam int DEPTH = 2 ** A_WID;

    // Decoded per-port request fields. Index 0 is port A and index 1 is port B.
    logic [B_WID-1:0]  bank_v [2];
    logic [A_WID-1:0]  row_v  [2];
    logic [1:0]        rd_en;
    logic              a_wr_en;
    logic              b_wr_en;
    logic              conflict;

    // Arbitration state. ptr_q == 0 means port A has priority.
    logic              ptr_q;
    logic              ptr_d;
    logic [15:0]       conflict_cnt_q;
    logic [15:0]       conflict_cnt_d;

    // Bank storage. Not reset.
    logic [D_WID-1:0]  mem_q [NUM_BANKS][DEPTH];

    // First read stage, one set per port. Each bank has its own output
    // register, and the bank index travels with the valid bit. The output
    // mux therefore selects the bank that was actually read.
    logic [D_WID-1:0]  bank_rd_q [2][NUM_BANKS];
    logic [D_WID-1:0]  bank_rd_d [2][NUM_BANKS];
    logic [B_WID-1:0]  rd_bank_q [2];
    logic [B_WID-1:0]  rd_bank_d [2];
    logic [1:0]        rv1_q;
    logic [1:0]        rv1_d;
    logic [D_WID-1:0]  rd_mux    [2];

    // Grant logic depends only on req, the bank bits and the pointer.
    // The we and wdata inputs affect only what the granted access does.
    always_comb begin
        bank_v[0] = a_addr[B_WID-1:0];
        bank_v[1] = b_addr[B_WID-1:0];
        row_v[0]  = a_addr[AW-1:B_WID];
        row_v[1]  = b_addr[AW-1:B_WID];

        conflict = a_req && b_req && (bank_v[0] == bank_v[1]);
        a_gnt    = a_req && !(conflict && ptr_q);
        b_gnt    = b_req && !(conflict && !ptr_q);

        // Writes are blocked during reset. Grants still follow the
        // arbitration rules while rst_n is low.
        a_wr_en  = a_gnt && a_we && rst_n;
        b_wr_en  = b_gnt && b_we && rst_n;
        rd_en[0] = a_gnt && !a_we;
        rd_en[1] = b_gnt && !b_we;

        ptr_d = conflict ? !ptr_q : ptr_q;
        conflict_cnt_d = (conflict && (conflict_cnt_q != 16'hFFFF))
                         ? conflict_cnt_q + 16'd1 : conflict_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            ptr_q          <= ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;

    // A conflict guarantees that the two enables never target the same
    // bank, so the two writes below never collide.
    always_ff @(posedge clk) begin
        if (a_wr_en) mem_q[bank_v[0]][row_v[0]] <= a_wdata;
        if (b_wr_en) mem_q[bank_v[1]][row_v[1]] <= b_wdata;
    end

    // Reads sample mem_q before any write at the same edge lands.
    always_comb begin
        bank_rd_d = bank_rd_q;
        rd_bank_d = rd_bank_q;
        rv1_d     = rd_en;
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                rd_bank_d[p]            = bank_v[p];
                bank_rd_d[p][bank_v[p]] = mem_q[bank_v[p]][row_v[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1_q <= '0;
            for (int p = 0; p < 2; p++) begin
                rd_bank_q[p] <= '0;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    bank_rd_q[p][b] <= '0;
                end
            end
        end else begin
            rv1_q     <= rv1_d;
            rd_bank_q <= rd_bank_d;
            bank_rd_q <= bank_rd_d;
        end
    end

    // rd_bank_q and the selected bank register change only on a read.
    // The muxed value therefore holds steady between rvalid pulses.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_mux[p] = bank_rd_q[p][rd_bank_q[p]];
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [1:0]       rv2_q;
        logic [1:0]       rv2_d;
        logic [D_WID-1:0] rd2_q [2];
        logic [D_WID-1:0] rd2_d [2];

        always_comb begin
            rv2_d = rv1_q;
            rd2_d = rd2_q;
            for (int p = 0; p < 2; p++) begin
                if (rv1_q[p]) rd2_d[p] = rd_mux[p];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv2_q    <= '0;
                rd2_q[0] <= '0;
                rd2_q[1] <= '0;
            end else begin
                rv2_q <= rv2_d;
                rd2_q <= rd2_d;
            end
        end

        assign a_rvalid = rv2_q[0];
        assign b_rvalid = rv2_q[1];
        assign a_rdata  = rd2_q[0];
        assign b_rdata  = rd2_q[1];
    end else begin : g_no_out_reg
        assign a_rvalid = rv1_q[0];
        assign b_rvalid = rv1_q[1];
        assign a_rdata  = rd_mux[0];
        assign b_rdata  = rd_mux[1];
    end

endmodule

// File: tb/tb_banked_scratchpad.sv
// ---------------------------------------------------------------------------
// tb_banked_scratchpad
//
// Testbench for banked_scratchpad. Two instances share the same inputs:
// u0 has OUT_REG=0 and u1 has OUT_REG=1. The main vector table checks u0
// directly. u1 is expected to reproduce u0's read results one cycle later.
// Hand-written sequences cover reset in the middle of a read, conflict
// hand-off after reset, a streaming pass over every bank, and counter
// saturation.
// ---------------------------------------------------------------------------
module tb_banked_scratchpad;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [13:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;

    logic        a_gnt0, b_gnt0, a_rv0, b_rv0;
    logic [7:0]  a_rd0, b_rd0;
    logic [15:0] cnt0;
    logic        a_gnt1, b_gnt1, a_rv1, b_rv1;
    logic [7:0]  a_rd1, b_rd1;
    logic [15:0] cnt1;

    int checks;
    int errors;

    typedef struct packed {
        logic        a_req;
        logic        a_we;
        logic [13:0] a_addr;
        logic [7:0]  a_wdata;
        logic        b_req;
        logic        b_we;
        logic [13:0] b_addr;
        logic [7:0]  b_wdata;
        logic        exp_a_gnt;
        logic        exp_b_gnt;
        logic        exp_a_rv;
        logic        exp_b_rv;
        logic [7:0]  exp_a_rd;
        logic [7:0]  exp_b_rd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [12];

    banked_scratchpad #(.NUM_BANKS(16), .A_WID(10), .D_WID(8), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt0), .b_gnt(b_gnt0), .a_rvalid(a_rv0), .b_rvalid(b_rv0),
        .a_rdata(a_rd0), .b_rdata(b_rd0), .conflict_cnt(cnt0)
    );

    banked_scratchpad #(.NUM_BANKS(16), .A_WID(10), .D_WID(8), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt1), .b_gnt(b_gnt1), .a_rvalid(a_rv1), .b_rvalid(b_rv1),
        .a_rdata(a_rd1), .b_rdata(b_rd1), .conflict_cnt(cnt1)
    );

    // 10 ns clock. Inputs change on the falling edge and outputs are
    // sampled 3 ns later, well away from the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle's worth of port inputs from a vector record.
    task automatic applyStimulus(input vec_t v);
        a_req   = v.a_req;
        a_we    = v.a_we;
        a_addr  = v.a_addr;
        a_wdata = v.a_wdata;
        b_req   = v.b_req;
        b_we    = v.b_we;
        b_addr  = v.b_addr;
        b_wdata = v.b_wdata;
    endtask

    // Drives port inputs directly, for the hand-written sequences.
    task automatic drive(input logic ar, input logic aw, input logic [13:0] aa,
                         input logic [7:0] ad, input logic br, input logic bw,
                         input logic [13:0] ba, input logic [7:0] bd);
        vec_t v;
        v = '0;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
        applyStimulus(v);
    endtask

    // Compares one observed value against its expected value and counts it.
    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected stored data for the streaming pass.
    function automatic logic [7:0] pat(input int k);
        return 8'(k * 37 + 5);
    endfunction

    // Expected results for the second instance, which lags u0 by one cycle.
    logic       prev_a_rv, prev_b_rv;
    logic [7:0] prev_a_rd, prev_b_rd;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0);

        // Fields: a_req a_we a_addr a_wdata | b_req b_we b_addr b_wdata |
        //         gntA gntB | rvA rvB | rdA rdB | cnt
        vecs[0]  = '{1'b1,1'b1,14'h000,8'h11, 1'b1,1'b1,14'h001,8'h22, 1'b1,1'b1, 1'b0,1'b0, 8'h00,8'h00, 16'd0};
        vecs[1]  = '{1'b1,1'b1,14'h003,8'h33, 1'b1,1'b1,14'h013,8'h44, 1'b1,1'b0, 1'b0,1'b0, 8'h00,8'h00, 16'd0};
        vecs[2]  = '{1'b0,1'b0,14'h000,8'h00, 1'b1,1'b1,14'h013,8'h44, 1'b0,1'b1, 1'b0,1'b0, 8'h00,8'h00, 16'd1};
        vecs[3]  = '{1'b1,1'b0,14'h000,8'h00, 1'b1,1'b0,14'h001,8'h00, 1'b1,1'b1, 1'b0,1'b0, 8'h00,8'h00, 16'd1};
        vecs[4]  = '{1'b1,1'b0,14'h003,8'h00, 1'b1,1'b0,14'h013,8'h00, 1'b0,1'b1, 1'b1,1'b1, 8'h11,8'h22, 16'd1};
        vecs[5]  = '{1'b1,1'b0,14'h003,8'h00, 1'b0,1'b0,14'h000,8'h00, 1'b1,1'b0, 1'b0,1'b1, 8'h11,8'h44, 16'd2};
        vecs[6]  = '{1'b0,1'b0,14'h000,8'h00, 1'b0,1'b0,14'h000,8'h00, 1'b0,1'b0, 1'b1,1'b0, 8'h33,8'h44, 16'd2};
        vecs[7]  = '{1'b1,1'b1,14'h050,8'h5A, 1'b1,1'b0,14'h001,8'h00, 1'b1,1'b1, 1'b0,1'b0, 8'h33,8'h44, 16'd2};
        vecs[8]  = '{1'b1,1'b0,14'h050,8'h00, 1'b1,1'b1,14'h001,8'h66, 1'b1,1'b1, 1'b0,1'b1, 8'h33,8'h22, 16'd2};
        vecs[9]  = '{1'b1,1'b1,14'h050,8'hA5, 1'b1,1'b0,14'h001,8'h00, 1'b1,1'b1, 1'b1,1'b0, 8'h5A,8'h22, 16'd2};
        vecs[10] = '{1'b1,1'b0,14'h050,8'h00, 1'b0,1'b0,14'h000,8'h00, 1'b1,1'b0, 1'b0,1'b1, 8'h5A,8'h66, 16'd2};
        vecs[11] = '{1'b0,1'b0,14'h000,8'h00, 1'b0,1'b0,14'h000,8'h00, 1'b0,1'b0, 1'b1,1'b0, 8'hA5,8'h66, 16'd2};

        // Check the reset state of both instances.
        repeat (3) @(negedge clk);
        #3;
        checkOutput("reset u0 a_rvalid", 16'(a_rv0), 16'd0);
        checkOutput("reset u0 b_rvalid", 16'(b_rv0), 16'd0);
        checkOutput("reset u0 a_rdata", 16'(a_rd0), 16'd0);
        checkOutput("reset u0 b_rdata", 16'(b_rd0), 16'd0);
        checkOutput("reset u0 cnt", cnt0, 16'd0);
        checkOutput("reset u1 a_rvalid", 16'(a_rv1), 16'd0);
        checkOutput("reset u1 b_rvalid", 16'(b_rv1), 16'd0);
        checkOutput("reset u1 a_rdata", 16'(a_rd1), 16'd0);
        checkOutput("reset u1 b_rdata", 16'(b_rd1), 16'd0);
        checkOutput("reset u1 cnt", cnt1, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Run the directed vector table. u1 must show u0's previous-cycle
        // expectation.
        prev_a_rv = 1'b0; prev_b_rv = 1'b0; prev_a_rd = 8'h00; prev_b_rd = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("v%0d a_gnt", i), 16'(a_gnt0), 16'(vecs[i].exp_a_gnt));
            checkOutput($sformatf("v%0d b_gnt", i), 16'(b_gnt0), 16'(vecs[i].exp_b_gnt));
            checkOutput($sformatf("v%0d u0 a_rvalid", i), 16'(a_rv0), 16'(vecs[i].exp_a_rv));
            checkOutput($sformatf("v%0d u0 b_rvalid", i), 16'(b_rv0), 16'(vecs[i].exp_b_rv));
            checkOutput($sformatf("v%0d u0 a_rdata", i), 16'(a_rd0), 16'(vecs[i].exp_a_rd));
            checkOutput($sformatf("v%0d u0 b_rdata", i), 16'(b_rd0), 16'(vecs[i].exp_b_rd));
            checkOutput($sformatf("v%0d u0 cnt", i), cnt0, vecs[i].exp_cnt);
            checkOutput($sformatf("v%0d u1 a_rvalid", i), 16'(a_rv1), 16'(prev_a_rv));
            checkOutput($sformatf("v%0d u1 b_rvalid", i), 16'(b_rv1), 16'(prev_b_rv));
            checkOutput($sformatf("v%0d u1 a_rdata", i), 16'(a_rd1), 16'(prev_a_rd));
            checkOutput($sformatf("v%0d u1 b_rdata", i), 16'(b_rd1), 16'(prev_b_rd));
            checkOutput($sformatf("v%0d u1 cnt", i), cnt1, vecs[i].exp_cnt);
            prev_a_rv = vecs[i].exp_a_rv;
            prev_b_rv = vecs[i].exp_b_rv;
            prev_a_rd = vecs[i].exp_a_rd;
            prev_b_rd = vecs[i].exp_b_rd;
        end

        // Reset while a read is in flight. A write attempted during reset
        // must not land, and memory contents must survive the reset.
        @(negedge clk);
        drive(1, 0, 14'h003, 8'h00, 0, 0, 14'h000, 8'h00);
        #3;
        checkOutput("rst-mid a_gnt", 16'(a_gnt0), 16'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst-mid u0 a_rvalid", 16'(a_rv0), 16'd0);
        checkOutput("rst-mid u0 a_rdata", 16'(a_rd0), 16'd0);
        checkOutput("rst-mid u0 b_rdata", 16'(b_rd0), 16'd0);
        checkOutput("rst-mid u0 cnt", cnt0, 16'd0);
        checkOutput("rst-mid u1 a_rvalid", 16'(a_rv1), 16'd0);
        checkOutput("rst-mid u1 a_rdata", 16'(a_rd1), 16'd0);
        checkOutput("rst-mid u1 b_rdata", 16'(b_rd1), 16'd0);
        checkOutput("rst-mid u1 cnt", cnt1, 16'd0);
        @(negedge clk);
        drive(0, 0, 14'h000, 8'h00, 1, 1, 14'h013, 8'hEE);
        #3;
        checkOutput("in-reset b_gnt", 16'(b_gnt0), 16'd1);
        @(negedge clk);
        drive(1, 0, 14'h003, 8'h00, 1, 0, 14'h013, 8'h00);
        #3;
        checkOutput("in-reset conflict a_gnt", 16'(a_gnt0), 16'd1);
        checkOutput("in-reset conflict b_gnt", 16'(b_gnt0), 16'd0);
        @(negedge clk);
        drive(0, 0, 14'h000, 8'h00, 0, 0, 14'h000, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            checkOutput($sformatf("post-rst%0d u0 a_rvalid", k), 16'(a_rv0), 16'd0);
            checkOutput($sformatf("post-rst%0d u1 a_rvalid", k), 16'(a_rv1), 16'd0);
            checkOutput($sformatf("post-rst%0d u1 b_rvalid", k), 16'(b_rv1), 16'd0);
            @(negedge clk);
        end

        // Both ports read bank 3 after reset. A wins first and B is served
        // on the next cycle.
        drive(1, 0, 14'h003, 8'h00, 1, 0, 14'h013, 8'h00);
        #3;
        checkOutput("conf a_gnt", 16'(a_gnt0), 16'd1);
        checkOutput("conf b_gnt", 16'(b_gnt0), 16'd0);
        checkOutput("conf cnt before", cnt0, 16'd0);
        @(negedge clk);
        drive(0, 0, 14'h000, 8'h00, 1, 0, 14'h013, 8'h00);
        #3;
        checkOutput("conf b_gnt next", 16'(b_gnt0), 16'd1);
        checkOutput("conf u0 a_rvalid", 16'(a_rv0), 16'd1);
        checkOutput("conf u0 a_rdata", 16'(a_rd0), 16'h33);
        checkOutput("conf u0 b_rvalid early", 16'(b_rv0), 16'd0);
        checkOutput("conf cnt after", cnt0, 16'd1);
        @(negedge clk);
        drive(0, 0, 14'h000, 8'h00, 0, 0, 14'h000, 8'h00);
        #3;
        checkOutput("conf u0 b_rvalid", 16'(b_rv0), 16'd1);
        checkOutput("conf u0 b_rdata retained", 16'(b_rd0), 16'h44);
        checkOutput("conf u0 a_rvalid drop", 16'(a_rv0), 16'd0);
        checkOutput("conf u1 a_rvalid", 16'(a_rv1), 16'd1);
        checkOutput("conf u1 a_rdata", 16'(a_rd1), 16'h33);
        @(negedge clk);
        #3;
        checkOutput("conf u1 b_rvalid", 16'(b_rv1), 16'd1);
        checkOutput("conf u1 b_rdata", 16'(b_rd1), 16'h44);
        checkOutput("conf u1 a_rvalid drop", 16'(a_rv1), 16'd0);
        checkOutput("conf u0 b_rvalid drop", 16'(b_rv0), 16'd0);

        // Streaming pass over all 16 banks x 4 rows. Port A writes every
        // address, then A reads upward while B reads downward. These two
        // read sequences never hit the same bank in the same cycle.
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            drive(1, 1, 14'(k), pat(k), 0, 0, 14'h000, 8'h00);
            #3;
            checkOutput($sformatf("stream wr%0d a_gnt", k), 16'(a_gnt0), 16'd1);
        end
        for (int k = 0; k < 66; k++) begin
            @(negedge clk);
            if (k < 64) drive(1, 0, 14'(k), 8'h00, 1, 0, 14'(63 - k), 8'h00);
            else        drive(0, 0, 14'h000, 8'h00, 0, 0, 14'h000, 8'h00);
            #3;
            checkOutput($sformatf("stream rd%0d u0 a_rvalid", k), 16'(a_rv0), 16'(k >= 1 && k <= 64));
            checkOutput($sformatf("stream rd%0d u0 b_rvalid", k), 16'(b_rv0), 16'(k >= 1 && k <= 64));
            checkOutput($sformatf("stream rd%0d u1 a_rvalid", k), 16'(a_rv1), 16'(k >= 2));
            checkOutput($sformatf("stream rd%0d u1 b_rvalid", k), 16'(b_rv1), 16'(k >= 2));
            if (k >= 1 && k <= 64) begin
                checkOutput($sformatf("stream rd%0d u0 a_rdata", k), 16'(a_rd0), 16'(pat(k - 1)));
                checkOutput($sformatf("stream rd%0d u0 b_rdata", k), 16'(b_rd0), 16'(pat(64 - k)));
            end
            if (k >= 2) begin
                checkOutput($sformatf("stream rd%0d u1 a_rdata", k), 16'(a_rd1), 16'(pat(k - 2)));
                checkOutput($sformatf("stream rd%0d u1 b_rdata", k), 16'(b_rd1), 16'(pat(65 - k)));
            end
        end

        // Hold a same-bank conflict on every cycle until the counter
        // saturates. The count resumes from 1 after the earlier conflict.
        @(negedge clk);
        drive(1, 0, 14'h000, 8'h00, 1, 0, 14'h010, 8'h00);
        repeat (100) @(posedge clk);
        #3;
        checkOutput("sat u0 cnt 101", cnt0, 16'd101);
        checkOutput("sat u1 cnt 101", cnt1, 16'd101);
        repeat (65500) @(posedge clk);
        #3;
        checkOutput("sat u0 cnt max", cnt0, 16'hFFFF);
        checkOutput("sat u1 cnt max", cnt1, 16'hFFFF);
        repeat (10) @(posedge clk);
        #3;
        checkOutput("sat u0 cnt hold", cnt0, 16'hFFFF);
        checkOutput("sat u1 cnt hold", cnt1, 16'hFFFF);
        @(negedge clk);
        drive(0, 0, 14'h000, 8'h00, 0, 0, 14'h000, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
